// File: rtl/board_pkg.sv
// Board-level widths shared by every block that touches the pins.
package board_pkg;
    localparam int KEYS_W = 3;
    localparam int LEDS_W = 2;
endpackage

// File: rtl/game_pkg.sv
// Round-sequencer state encoding and default timing, shared with the overlay renderer.
package game_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5
    } game_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_SERVE_FRAMES    = 60;
endpackage

// File: rtl/key_debounce.sv
// One board key: 2-FF synchronizer, stability counter and registered press pulse.
module key_debounce
    import game_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_prev_q;
    logic             press_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            // Polarity is normalized before the synchronizer so 1 always means pressed.
            sync_q       <= {sync_q[0], key_i ^ KEY_ACTIVE_LOW};
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong round sequencer: start key, serve/play/point/over flow, scores and board LEDs.
module pong_game_ctrl
    import game_pkg::*;
#(
    parameter int KEYS_W          = board_pkg::KEYS_W,
    parameter int LEDS_W          = board_pkg::LEDS_W,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SCORE_W         = 4,
    parameter int WIN_SCORE       = 9,
    parameter int SERVE_FRAMES    = DEFAULT_SERVE_FRAMES,
    parameter int BLINK_FRAMES    = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [KEYS_W-1:0]  keys_i,
    input  logic               frame_tick_i,
    input  logic               miss_left_i,
    input  logic               miss_right_i,
    output logic               ball_run_o,
    output logic               ball_reset_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] score_left_o,
    output logic [SCORE_W-1:0] score_right_o,
    output logic               winner_o,
    output logic [2:0]         state_o,
    output logic [LEDS_W-1:0]  leds_o
);
    localparam int FRAME_MAX = (SERVE_FRAMES > BLINK_FRAMES) ? SERVE_FRAMES : BLINK_FRAMES;
    localparam int FCNT_W    = $clog2(FRAME_MAX + 1);
    localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  BLINK_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               ball_run_q, ball_reset_q, blink_q;
    logic [FCNT_W-1:0]  frame_cnt_q;
    logic               start_pulse;
    logic               key_level;
    logic               unused_bits;

    key_debounce #(
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_key (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .key_i   (keys_i[0]),
        .level_o (key_level),
        .press_o (start_pulse)
    );

    // Only key 0 drives this block; the other keys belong to the paddle logic.
    assign unused_bits = ^{keys_i[KEYS_W-1:1], key_level};

    // NOTE: every variable gets its hold value first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        unique case (state_q)
            IDLE: begin
                score_left_d  = '0;
                score_right_d = '0;
                winner_d      = 1'b0;
                if (start_pulse) state_d = SERVE;
            end
            SERVE: begin
                if (frame_tick_i && frame_cnt_q == SERVE_LAST) state_d = PLAY;
            end
            PLAY: begin
                // A miss always beats a coincident start; a double miss scores nobody.
                if (miss_left_i && miss_right_i) begin
                    state_d = POINT;
                end else if (miss_right_i) begin
                    score_left_d = score_left_q + 1'b1;
                    serve_dir_d  = 1'b1;
                    state_d      = POINT;
                end else if (miss_left_i) begin
                    score_right_d = score_right_q + 1'b1;
                    serve_dir_d   = 1'b0;
                    state_d       = POINT;
                end else if (start_pulse) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_pulse) state_d = PLAY;
            end
            POINT: begin
                if (frame_tick_i) begin
                    if (score_left_q == WIN) begin
                        winner_d = 1'b0;
                        state_d  = OVER;
                    end else if (score_right_q == WIN) begin
                        winner_d = 1'b1;
                        state_d  = OVER;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            OVER: begin
                if (start_pulse) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    winner_d      = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            ball_run_q    <= 1'b0;
            ball_reset_q  <= 1'b0;
            frame_cnt_q   <= '0;
            blink_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            // Registered from the next state so outputs line up with state_o.
            ball_run_q    <= (state_d == PLAY);
            ball_reset_q  <= (state_d == SERVE) && (state_q != SERVE);
            if (state_d != state_q) begin
                frame_cnt_q <= '0;
                blink_q     <= 1'b0;
            end else if (frame_tick_i) begin
                if (state_q == SERVE) begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end else if (state_q == OVER) begin
                    if (frame_cnt_q == BLINK_LAST) begin
                        frame_cnt_q <= '0;
                        blink_q     <= ~blink_q;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        leds_o    = '0;
        leds_o[0] = ball_run_q;
        leds_o[1] = blink_q;
    end

    assign ball_run_o    = ball_run_q;
    assign ball_reset_o  = ball_reset_q;
    assign serve_dir_o   = serve_dir_q;
    assign score_left_o  = score_left_q;
    assign score_right_o = score_right_q;
    assign winner_o      = winner_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short debounce/serve/win/blink settings.
module tb_pong_game_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] keys = 3'b111;
    logic       frame_tick = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_run, ball_reset, serve_dir, winner;
    logic [3:0] score_left, score_right;
    logic [2:0] state;
    logic [1:0] leds;

    int checks = 0;
    int errors = 0;
    int start_count = 0;

    pong_game_ctrl #(
        .KEYS_W          (3),
        .LEDS_W          (2),
        .KEY_ACTIVE_LOW  (1'b1),
        .DEBOUNCE_CYCLES (4),
        .SCORE_W         (4),
        .WIN_SCORE       (2),
        .SERVE_FRAMES    (3),
        .BLINK_FRAMES    (2)
    ) u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .keys_i        (keys),
        .frame_tick_i  (frame_tick),
        .miss_left_i   (miss_left),
        .miss_right_i  (miss_right),
        .ball_run_o    (ball_run),
        .ball_reset_o  (ball_reset),
        .serve_dir_o   (serve_dir),
        .score_left_o  (score_left),
        .score_right_o (score_right),
        .winner_o      (winner),
        .state_o       (state),
        .leds_o        (leds)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (u_dut.start_pulse) start_count++;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    // Full debounced press: start pulse lands on edge 7, state moves on edge 8.
    task automatic press();
        keys[0] = 1'b0;
        step(8);
        keys[0] = 1'b1;
        step(8);
    endtask

    task automatic serve_to_play();
        frame();
        frame();
        frame();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_scores"}, {24'd0, score_left, score_right}, 32'd0);
        check({tag, "_winner"}, 32'(winner), 32'd0);
        check({tag, "_serve_dir"}, 32'(serve_dir), 32'd1);
        check({tag, "_run_reset"}, {30'd0, ball_run, ball_reset}, 32'd0);
        check({tag, "_leds"}, 32'(leds), 32'd0);
    endtask

    initial begin
        step(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        step(2);

        // 3-cycle glitch is shorter than the debounce window
        keys[0] = 1'b0;
        step(3);
        keys[0] = 1'b1;
        step(8);
        check("glitch_pulses", 32'(start_count), 32'd0);
        check("glitch_state", 32'(state), 32'(IDLE));

        // held press: pulse 7 cycles after the press edge, SERVE one cycle later
        keys[0] = 1'b0;
        step(7);
        check("press_pulse_7", 32'(u_dut.start_pulse), 32'd1);
        check("press_idle_7", 32'(state), 32'(IDLE));
        step(1);
        check("press_serve", 32'(state), 32'(SERVE));
        check("serve_ball_reset", 32'(ball_reset), 32'd1);
        step(1);
        check("serve_reset_drop", 32'(ball_reset), 32'd0);
        step(1);
        keys[0] = 1'b1;
        step(8);
        check("press_one_pulse", 32'(start_count), 32'd1);
        check("serve_hold", 32'(state), 32'(SERVE));

        frame();
        frame();
        check("serve_two_ticks", 32'(state), 32'(SERVE));
        frame();
        check("play_state", 32'(state), 32'(PLAY));
        check("play_run", 32'(ball_run), 32'd1);
        check("play_leds", 32'(leds), 32'd1);

        miss_right = 1'b1;
        step(1);
        miss_right = 1'b0;
        check("miss_r_state", 32'(state), 32'(POINT));
        check("miss_r_score", {24'd0, score_left, score_right}, 32'h10);
        check("miss_r_dir", 32'(serve_dir), 32'd1);
        check("miss_r_run", 32'(ball_run), 32'd0);

        frame();
        check("point_serve", 32'(state), 32'(SERVE));
        check("point_ball_reset", 32'(ball_reset), 32'd1);
        step(1);
        check("point_reset_drop", 32'(ball_reset), 32'd0);
        serve_to_play();
        check("play2_state", 32'(state), 32'(PLAY));

        // double miss together with a start pulse
        keys[0] = 1'b0;
        step(7);
        miss_left = 1'b1;
        miss_right = 1'b1;
        step(1);
        miss_left = 1'b0;
        miss_right = 1'b0;
        check("dbl_state", 32'(state), 32'(POINT));
        check("dbl_score", {24'd0, score_left, score_right}, 32'h10);
        check("dbl_dir", 32'(serve_dir), 32'd1);
        keys[0] = 1'b1;
        step(8);
        check("dbl_start_dropped", 32'(state), 32'(POINT));

        frame();
        serve_to_play();
        check("play3_state", 32'(state), 32'(PLAY));

        press();
        check("pause_state", 32'(state), 32'(PAUSE));
        check("pause_run", 32'(ball_run), 32'd0);
        miss_right = 1'b1;
        step(1);
        miss_right = 1'b0;
        check("pause_miss_state", 32'(state), 32'(PAUSE));
        check("pause_miss_score", {24'd0, score_left, score_right}, 32'h10);
        press();
        check("resume_state", 32'(state), 32'(PLAY));
        check("resume_run", 32'(ball_run), 32'd1);

        miss_left = 1'b1;
        step(1);
        miss_left = 1'b0;
        check("miss_l_score", {24'd0, score_left, score_right}, 32'h11);
        check("miss_l_dir", 32'(serve_dir), 32'd0);
        frame();
        check("tie_serve", 32'(state), 32'(SERVE));
        serve_to_play();

        miss_right = 1'b1;
        step(1);
        miss_right = 1'b0;
        check("win_score", {24'd0, score_left, score_right}, 32'h21);
        check("win_dir", 32'(serve_dir), 32'd1);
        frame();
        check("over_state", 32'(state), 32'(OVER));
        check("over_winner", 32'(winner), 32'd0);
        check("over_leds_entry", 32'(leds), 32'd0);
        miss_left = 1'b1;
        step(1);
        miss_left = 1'b0;
        check("over_frozen", {24'd0, score_left, score_right}, 32'h21);
        frame();
        check("blink_f1", 32'(leds), 32'd0);
        frame();
        check("blink_f2", 32'(leds), 32'd2);
        frame();
        check("blink_f3", 32'(leds), 32'd2);
        frame();
        check("blink_f4", 32'(leds), 32'd0);

        press();
        check("restart_state", 32'(state), 32'(IDLE));
        check("restart_scores", {24'd0, score_left, score_right}, 32'd0);
        check("restart_winner", 32'(winner), 32'd0);

        press();
        serve_to_play();
        check("play4_run", 32'(ball_run), 32'd1);
        rst_n = 1'b0;
        #2;
        check_reset_values("midgame_reset");
        step(1);
        rst_n = 1'b1;
        step(2);
        check("post_reset_state", 32'(state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
